regfile_sb: RTL and testbench



---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_sb_rdport.sv | 40 ++++
 rtl/regfile_sb.sv | 111 +++++++++++
 tb/tb_regfile_sb.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and helpers for the regfile_sb register file.
//   DATA_W_DEF / ADDR_W_DEF / NUM_RD_DEF : default geometry
//   CNT_W_DEF                            : default busy-count width (ADDR_W+1)
//   slice_lo()                           : low bit of element idx in a packed bus
//   cnt_width()                          : busy-count width for a given ADDR_W
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned NUM_RD_DEF = 3;
  localparam int unsigned CNT_W_DEF  = ADDR_W_DEF + 1;

  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

  // Count must hold DEPTH = 2**aw itself, hence one extra bit.
  function automatic int unsigned cnt_width(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/regfile_sb_rdport.sv
// regfile_sb_rdport: one combinational read port of regfile_sb.
//   rd_addr    : register address for this port
//   regs       : full register array contents
//   busy       : per-register busy vector
//   wr_en      : effective (reset/zero-reg gated) writeback strobe
//   wr_addr    : writeback address
//   wr_data    : writeback data, bypassed on address match
//   claim_set  : a claim is accepted and will set busy this edge
//   claim_addr : claimed register
//   rd_data    : read data (bypassed when written this cycle)
//   rd_busy    : busy flag of the addressed register
module regfile_sb_rdport #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
) (
  input  logic [ADDR_W-1:0]                     rd_addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
  input  logic [(2**ADDR_W)-1:0]                busy,
  input  logic                                  wr_en,
  input  logic [ADDR_W-1:0]                     wr_addr,
  input  logic [DATA_W-1:0]                     wr_data,
  input  logic                                  claim_set,
  input  logic [ADDR_W-1:0]                     claim_addr,
  output logic [DATA_W-1:0]                     rd_data,
  output logic                                  rd_busy
);

  logic wr_hit;
  logic claim_hit;

  always_comb begin
    wr_hit    = wr_en & (wr_addr == rd_addr);
    claim_hit = claim_set & (claim_addr == rd_addr);
    rd_data   = wr_hit ? wr_data : regs[rd_addr];
    // A write being bypassed retires the old producer; only a same-cycle
    // accepted claim keeps the register marked busy.
    rd_busy   = wr_hit ? claim_hit : busy[rd_addr];
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write-through bypass and a
// per-register busy scoreboard for pipeline interlocking.
//   clk, rst_n  : clock, asynchronous active-low reset
//   rd_addr     : packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data     : packed read data (combinational, bypassed)
//   rd_busy     : busy flag per read port (combinational)
//   wr_en/addr/data : writeback; clears busy of the written register
//   claim_en/addr   : decode reserves a destination register
//   claim_stall : claim refused this cycle (WAW on a busy register)
//   busy_count  : number of busy registers (registered)
// Build option: define REGFILE_ZERO_REG_EN to hardwire register 0 to zero
// (writes dropped, claims accepted but never set busy).
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     claim_en,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     claim_stall,
  output logic [ADDR_W:0]          busy_count
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned CNT_W = cnt_width(ADDR_W);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0]             busy_n;
  logic [CNT_W-1:0]             count;
  logic [CNT_W-1:0]             count_n;
  logic                         wr_zero;
  logic                         claim_zero;
  logic                         wr_eff;
  logic                         claim_acc;
  logic                         claim_set;
  logic                         inc;
  logic                         dec;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_zero    = (wr_addr == '0);
  assign claim_zero = (claim_addr == '0);
`else
  assign wr_zero    = 1'b0;
  assign claim_zero = 1'b0;
`endif

  always_comb begin
    wr_eff      = rst_n & wr_en & ~wr_zero;
    claim_stall = rst_n & claim_en & busy[claim_addr] &
                  ~(wr_eff & (wr_addr == claim_addr));
    claim_acc   = rst_n & claim_en & ~claim_stall;
    claim_set   = claim_acc & ~claim_zero;

    // Same-address write+claim leaves the bit set: the count only moves
    // when the bit actually changes state.
    inc = claim_set & ~busy[claim_addr];
    dec = wr_eff & busy[wr_addr] & ~(claim_set & (claim_addr == wr_addr));

    busy_n = busy;
    if (wr_eff)    busy_n[wr_addr]    = 1'b0;
    if (claim_set) busy_n[claim_addr] = 1'b1;

    count_n = count + CNT_W'(inc) - CNT_W'(dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs  <= '0;
      busy  <= '0;
      count <= '0;
    end else begin
      if (wr_eff) regs[wr_addr] <= wr_data;
      busy  <= busy_n;
      count <= count_n;
    end
  end

  assign busy_count = count;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    localparam int unsigned A_LO = slice_lo(i, ADDR_W);
    localparam int unsigned D_LO = slice_lo(i, DATA_W);
    regfile_sb_rdport #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W)
    ) u_rdport (
      .rd_addr    (rd_addr[A_LO +: ADDR_W]),
      .regs       (regs),
      .busy       (busy),
      .wr_en      (wr_eff),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .claim_set  (claim_set),
      .claim_addr (claim_addr),
      .rd_data    (rd_data[D_LO +: DATA_W]),
      .rd_busy    (rd_busy[i])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: self-checking bench for regfile_sb (default geometry 4x8,
// three read ports). Directed table of vectors, hand sequences for reset
// and the zero-register option, then randomized traffic against a model.
module tb_regfile_sb;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [5:0]  rd_addr;
  logic [23:0] rd_data;
  logic [2:0]  rd_busy;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        claim_en;
  logic [1:0]  claim_addr;
  logic        claim_stall;
  logic [2:0]  busy_count;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_sb #(.DATA_W(8), .ADDR_W(2), .NUM_RD(3)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_stall(claim_stall),
    .busy_count(busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [7:0]  wd;
    logic        ce;
    logic [1:0]  ca;
    logic [5:0]  ra;
    logic [23:0] exp_data;
    logic [2:0]  exp_busy;
    logic        exp_stall;
    logic [2:0]  exp_cnt;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                              input logic ce, input logic [1:0] ca,
                              input logic [1:0] a0, input logic [1:0] a1, input logic [1:0] a2,
                              input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                              input logic b0, input logic b1, input logic b2,
                              input logic st, input logic [2:0] cnt);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ce = ce; v.ca = ca;
    v.ra = {a2, a1, a0};
    v.exp_data = {d2, d1, d0};
    v.exp_busy = {b2, b1, b0};
    v.exp_stall = st;
    v.exp_cnt = cnt;
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [7:0] m_mem [4];
  logic       m_bsy [4];

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_mem[i] = '0;
      m_bsy[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 4; i++) if (m_bsy[i]) c++;
    return c;
  endfunction

  function automatic logic model_stall();
    return claim_en && m_bsy[claim_addr] && !(wr_en && wr_addr == claim_addr);
  endfunction

  task automatic model_check();
    logic stall;
    logic accept;
    logic [1:0] a;
    logic [7:0] d;
    logic b;
    logic [5:0] ra;
    logic [23:0] rdd;
    stall  = model_stall();
    accept = claim_en && !stall && !(ZR && claim_addr == 2'd0);
    ra  = rd_addr;
    rdd = rd_data;
    for (int i = 0; i < 3; i++) begin
      a = ra[2*i +: 2];
      if (ZR && a == 2'd0) begin
        d = 8'h00; b = 1'b0;
      end else if (wr_en && wr_addr == a) begin
        d = wr_data; b = accept && claim_addr == a;
      end else begin
        d = m_mem[a]; b = m_bsy[a];
      end
      chk($sformatf("rnd_data%0d", i), 32'(rdd[8*i +: 8]), 32'(d));
      chk($sformatf("rnd_busy%0d", i), 32'(rd_busy[i]), 32'(b));
    end
    chk("rnd_stall", 32'(claim_stall), 32'(stall));
    chk("rnd_count", 32'(busy_count), 32'(model_count()));
  endtask

  // Applies the clock edge effect of the currently driven inputs.
  task automatic model_edge();
    logic stall;
    stall = model_stall();
    if (wr_en && !(ZR && wr_addr == 2'd0)) begin
      m_mem[wr_addr] = wr_data;
      m_bsy[wr_addr] = 1'b0;
    end
    if (claim_en && !stall && !(ZR && claim_addr == 2'd0))
      m_bsy[claim_addr] = 1'b1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    rd_addr = '0;

    // Reset with a pending write and claim: nothing may leak through.
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hFF;
    claim_en = 1'b1; claim_addr = 2'd2;
    rd_addr = {2'd1, 2'd1, 2'd1};
    #2;
    @(negedge clk);
    chk("rst_data", 32'(rd_data), 32'h0);
    chk("rst_busy", 32'(rd_busy), 32'h0);
    chk("rst_stall", 32'(claim_stall), 32'h0);
    chk("rst_count", 32'(busy_count), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("rst_reg1_after", 32'(rd_data), 32'h0);
    chk("rst_count_after", 32'(busy_count), 32'h0);
    tick();

`ifndef REGFILE_ZERO_REG_EN
    vt.push_back(mk(1,2,8'hA5,0,0, 2,2,2, 8'hA5,8'hA5,8'hA5, 0,0,0, 0,0));
    vt.push_back(mk(0,0,8'h00,0,0, 2,2,2, 8'hA5,8'hA5,8'hA5, 0,0,0, 0,0));
    vt.push_back(mk(0,0,8'h00,1,3, 3,2,0, 8'h00,8'hA5,8'h00, 0,0,0, 0,0));
    vt.push_back(mk(0,0,8'h00,1,3, 3,3,1, 8'h00,8'h00,8'h00, 1,1,0, 1,1));
    vt.push_back(mk(0,0,8'h00,0,0, 3,2,1, 8'h00,8'hA5,8'h00, 1,0,0, 0,1));
    vt.push_back(mk(1,3,8'h3C,0,0, 3,3,2, 8'h3C,8'h3C,8'hA5, 0,0,0, 0,1));
    vt.push_back(mk(0,0,8'h00,0,0, 3,1,2, 8'h3C,8'h00,8'hA5, 0,0,0, 0,0));
    vt.push_back(mk(0,0,8'h00,1,1, 1,0,2, 8'h00,8'h00,8'hA5, 0,0,0, 0,0));
    vt.push_back(mk(1,1,8'h5A,1,1, 1,1,3, 8'h5A,8'h5A,8'h3C, 1,1,0, 0,1));
    vt.push_back(mk(0,0,8'h00,0,0, 1,1,3, 8'h5A,8'h5A,8'h3C, 1,1,0, 0,1));
    vt.push_back(mk(1,1,8'h11,0,0, 1,2,3, 8'h11,8'hA5,8'h3C, 0,0,0, 0,1));
    vt.push_back(mk(0,0,8'h00,1,0, 0,1,2, 8'h00,8'h11,8'hA5, 0,0,0, 0,0));
    vt.push_back(mk(0,0,8'h00,1,1, 0,1,2, 8'h00,8'h11,8'hA5, 1,0,0, 0,1));
    vt.push_back(mk(0,0,8'h00,1,2, 0,1,2, 8'h00,8'h11,8'hA5, 1,1,0, 0,2));
    vt.push_back(mk(0,0,8'h00,1,3, 0,1,2, 8'h00,8'h11,8'hA5, 1,1,1, 0,3));
    vt.push_back(mk(0,0,8'h00,1,2, 3,3,3, 8'h3C,8'h3C,8'h3C, 1,1,1, 1,4));
    vt.push_back(mk(1,0,8'h10,0,0, 0,1,2, 8'h10,8'h11,8'hA5, 0,1,1, 0,4));
    vt.push_back(mk(1,1,8'h20,0,0, 1,2,3, 8'h20,8'hA5,8'h3C, 0,1,1, 0,3));
    vt.push_back(mk(1,2,8'h30,0,0, 2,3,0, 8'h30,8'h3C,8'h10, 0,1,0, 0,2));
    vt.push_back(mk(1,3,8'h40,0,0, 3,0,1, 8'h40,8'h10,8'h20, 0,0,0, 0,1));
    vt.push_back(mk(0,0,8'h00,0,0, 0,1,2, 8'h10,8'h20,8'h30, 0,0,0, 0,0));

    for (int k = 0; k < vt.size(); k++) begin
      wr_en = vt[k].we; wr_addr = vt[k].wa; wr_data = vt[k].wd;
      claim_en = vt[k].ce; claim_addr = vt[k].ca; rd_addr = vt[k].ra;
      @(negedge clk);
      chk($sformatf("vec%0d_data", k), 32'(rd_data), 32'(vt[k].exp_data));
      chk($sformatf("vec%0d_busy", k), 32'(rd_busy), 32'(vt[k].exp_busy));
      chk($sformatf("vec%0d_stall", k), 32'(claim_stall), 32'(vt[k].exp_stall));
      chk($sformatf("vec%0d_count", k), 32'(busy_count), 32'(vt[k].exp_cnt));
      tick();
    end
`else
    // Register 0 hardwired: write and claim of 0 in the same cycle.
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'h77;
    claim_en = 1'b1; claim_addr = 2'd0; rd_addr = '0;
    @(negedge clk);
    chk("zr_data_same", 32'(rd_data), 32'h0);
    chk("zr_busy_same", 32'(rd_busy), 32'h0);
    chk("zr_stall_same", 32'(claim_stall), 32'h0);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("zr_data_next", 32'(rd_data), 32'h0);
    chk("zr_busy_next", 32'(rd_busy), 32'h0);
    chk("zr_stall_next", 32'(claim_stall), 32'h0);
    chk("zr_count", 32'(busy_count), 32'h0);
    tick();
    idle();
`endif

    // Randomized traffic against the model, from a fresh reset.
    rst_n = 1'b0;
    idle();
    #1;
    model_reset();
    tick();
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rd_addr    = 6'($urandom);
      wr_en      = ($urandom_range(0, 99) < 35);
      wr_addr    = 2'($urandom_range(0, 3));
      wr_data    = 8'($urandom);
      claim_en   = ($urandom_range(0, 99) < 50);
      claim_addr = 2'($urandom_range(0, 3));
      if (cyc == 200) begin
        // Asynchronous reset between edges clears state at once.
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(busy_count), 32'h0);
        chk("midrst_data", 32'(rd_data), 32'h0);
        chk("midrst_busy", 32'(rd_busy), 32'h0);
        chk("midrst_stall", 32'(claim_stall), 32'h0);
        model_reset();
        #1;
        rst_n = 1'b1;
      end
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
